// File: rtl/gate_sweep_pkg.sv
// Shared types and limits for the gate truth-table sweeper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;

  localparam int unsigned SWEEP_MAX_N_IN = 4;

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable settle down-counter: load SETTLE-1, count down while enabled, zero_c flags 0.
module sweep_settle_cnt #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero_c
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/gate_truth_sweeper.sv
// Sweeps every input vector into a gate under test and checks its output against EXPECTED.
// Optional SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching sample.
module gate_truth_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned             N_IN     = 2,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = (2**N_IN)'(4'b0001),
  parameter int unsigned             SETTLE   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    y_i,
  output logic [N_IN-1:0]         vec_o,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           fail_count,
  output logic [N_IN-1:0]         first_fail_idx,
  output logic [(2**N_IN)-1:0]    captured
);

  localparam int unsigned NV = 2**N_IN;

  if ((N_IN == 0) || (N_IN > SWEEP_MAX_N_IN)) begin : g_bad_n_in
    $error("gate_truth_sweeper: N_IN=%0d outside 1..%0d", N_IN, SWEEP_MAX_N_IN);
  end
  if (SETTLE == 0) begin : g_bad_settle
    $error("gate_truth_sweeper: SETTLE must be >= 1");
  end

  sweep_state_t    state, state_nxt;
  logic [N_IN-1:0] idx;
  logic            cnt_load, cnt_en, cnt_zero_c;
  logic            mismatch_c, last_c, end_c;

  sweep_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .zero_c (cnt_zero_c)
  );

  assign mismatch_c = (y_i != EXPECTED[idx]);
  assign last_c     = (idx == N_IN'(NV - 1));
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign end_c      = last_c || mismatch_c;
`else
  assign end_c      = last_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = gate_sweep_pkg::SETTLE;
          cnt_load  = 1'b1;
        end
      end
      gate_sweep_pkg::SETTLE: begin
        if (cnt_zero_c) state_nxt = SAMPLE;
        else            cnt_en    = 1'b1;
      end
      SAMPLE: begin
        if (end_c) begin
          state_nxt = DONE;
        end else begin
          state_nxt = gate_sweep_pkg::SETTLE;
          cnt_load  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, drive and result registers; done pulses the cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      vec_o          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      captured       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx            <= '0;
            vec_o          <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            captured       <= '0;
          end
        end
        SAMPLE: begin
          captured[idx] <= y_i;
          if (mismatch_c) begin
            if (fail_count == '0) first_fail_idx <= idx;
            if (fail_count != (N_IN+1)'(NV)) fail_count <= fail_count + (N_IN+1)'(1);
          end
          if (!end_c) begin
            idx   <= idx + N_IN'(1);
            vec_o <= idx + N_IN'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (fail_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: directed gate cases plus random truth tables vs a table model.
module tb_gate_truth_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1, sel;
  logic [3:0] tbl0, tbl1;
  logic [1:0] vec0, vec1, ffi0, ffi1, s_vec, s_ffi;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic       s_busy, s_done, s_pass;
  logic [2:0] fc0, fc1, s_fc;
  logic [3:0] cap0, cap1, s_cap;
  logic       y0, y1;

  int total = 0;
  int bad   = 0;

  assign y0 = tbl0[vec0];
  assign y1 = tbl1[vec1];

  gate_truth_sweeper #(.N_IN(2), .EXPECTED(4'b0001), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_i(y0), .vec_o(vec0), .busy(busy0),
    .done(done0), .pass(pass0), .fail_count(fc0), .first_fail_idx(ffi0), .captured(cap0));

  gate_truth_sweeper #(.N_IN(2), .EXPECTED(4'b0001), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_i(y1), .vec_o(vec1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_count(fc1), .first_fail_idx(ffi1), .captured(cap1));

  assign s_vec  = sel ? vec1  : vec0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;
  assign s_pass = sel ? pass1 : pass0;
  assign s_fc   = sel ? fc1   : fc0;
  assign s_ffi  = sel ? ffi1  : ffi0;
  assign s_cap  = sel ? cap1  : cap0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // One sweep on dut0 (s=0, SETTLE=1) or dut1 (s=1, SETTLE=3) with the gate given as a truth table.
  task automatic run_sweep(input logic s, input logic [3:0] tbl, input bit extra, input string tag);
    logic [3:0] exp_tbl = 4'b0001;
    logic [3:0] mism, cap_e;
    logic [4:0] mask;
    int settle, first, nvec, fc_e, lat, n;
    bit found;
    int vals[$];
    int lens[$];

    settle = s ? 3 : 1;
    mism   = tbl ^ exp_tbl;
    found  = 0;
    first  = 0;
    for (int i = 0; i < 4; i++) begin
      if (mism[i] && !found) begin
        found = 1;
        first = i;
      end
    end
`ifdef SWEEP_STOP_ON_FAIL_EN
    if (found) begin
      mask  = (5'd1 << (first + 1)) - 5'd1;
      cap_e = tbl & mask[3:0];
      fc_e  = 1;
      nvec  = first + 1;
    end else begin
      cap_e = tbl;
      fc_e  = 0;
      nvec  = 4;
    end
`else
    mask  = 5'h1f;
    cap_e = tbl & mask[3:0];
    fc_e  = $countones(mism);
    nvec  = 4;
`endif
    lat = nvec * (settle + 1) + 1;

    sel = s;
    if (s) tbl1 = tbl;
    else   tbl0 = tbl;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
    chk({tag, ".busy_on"}, s_busy, 1'b1);

    vals.push_back(int'(s_vec));
    lens.push_back(1);
    n = 0;
    while (!s_done && n < 200) begin
      if (extra && n == 2)       set_start(s, 1'b1);
      if (extra && n == 3)       set_start(s, 1'b0);
      if (extra && n == lat - 1) set_start(s, 1'b1);
      tick();
      n++;
      if (int'(s_vec) == vals[$]) lens[$] = lens[$] + 1;
      else begin
        vals.push_back(int'(s_vec));
        lens.push_back(1);
      end
    end
    set_start(s, 1'b0);

    chk({tag, ".latency"}, n, lat);
    chk({tag, ".busy_off"}, s_busy, 1'b0);
    chk({tag, ".pass"}, s_pass, !found);
    chk({tag, ".fail_count"}, s_fc, fc_e);
    chk({tag, ".first_fail"}, s_ffi, first);
    chk({tag, ".captured"}, s_cap, cap_e);
    chk({tag, ".vec_runs"}, vals.size(), nvec);
    for (int i = 0; i < nvec - 1 && i < vals.size(); i++) begin
      chk({tag, ".vec_val"}, vals[i], i);
      chk({tag, ".vec_hold"}, lens[i], settle + 1);
    end

    tick();
    chk({tag, ".done_single"}, s_done, 1'b0);
    chk({tag, ".idle_after"}, s_busy, 1'b0);
    tick();
    tick();
    chk({tag, ".hold_pass"}, s_pass, !found);
    chk({tag, ".hold_cap"}, s_cap, cap_e);
  endtask

  initial begin
    int n, dones;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel    = 1'b0;
    tbl0   = 4'b0001;
    tbl1   = 4'b0001;
    #12;
    chk("rst.vec", s_vec, 2'd0);
    chk("rst.busy", s_busy, 1'b0);
    chk("rst.done", s_done, 1'b0);
    chk("rst.pass", s_pass, 1'b0);
    chk("rst.fc", s_fc, 3'd0);
    chk("rst.ffi", s_ffi, 2'd0);
    chk("rst.cap", s_cap, 4'd0);
    chk("rst.busy1", busy1, 1'b0);
    rst_n = 1'b1;
    tick();

    run_sweep(1'b0, 4'b0001, 1'b0, "nor");
    run_sweep(1'b0, 4'b0000, 1'b0, "stuck0");
    run_sweep(1'b0, 4'b1110, 1'b0, "or");
    run_sweep(1'b1, 4'b0001, 1'b0, "nor_settle3");
    run_sweep(1'b0, 4'b0001, 1'b1, "start_ignored");

    // Reset in the middle of a sweep: outputs clear and no done follows.
    sel    = 1'b0;
    tbl0   = 4'b0001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (vec0 != 2'd2 && n < 50) begin
      tick();
      n++;
    end
    chk("midrst.reach_vec2", vec0, 2'd2);
    rst_n = 1'b0;
    #2;
    chk("midrst.vec", vec0, 2'd0);
    chk("midrst.busy", busy0, 1'b0);
    chk("midrst.done", done0, 1'b0);
    chk("midrst.fc", fc0, 3'd0);
    chk("midrst.cap", cap0, 4'd0);
    #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done0) dones++;
    end
    chk("midrst.no_done", dones, 0);
    chk("midrst.idle", busy0, 1'b0);
    run_sweep(1'b0, 4'b0001, 1'b0, "restart");

    run_sweep(1'b0, 4'b1111, 1'b0, "stuck1");
    run_sweep(1'b1, 4'b1111, 1'b0, "stuck1_s3");

    for (int r = 0; r < 10; r++) begin
      run_sweep(1'($urandom_range(0, 1)), 4'($urandom), 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
